// File: rtl/video_in_store_burst_if.sv
// Wishbone classic write bus between the video input store stage and RAM.
interface video_in_store_burst_if;
    logic        STB_O;
    logic        CYC_O;
    logic        LOCK_O;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic        ACK_I;
    logic        ERR_I;

    modport master (
        output STB_O, CYC_O, LOCK_O, WE_O, SEL_O, ADR_O, DAT_O,
        input  ACK_I, ERR_I
    );

    modport slave (
        input  STB_O, CYC_O, LOCK_O, WE_O, SEL_O, ADR_O, DAT_O,
        output ACK_I, ERR_I
    );
endinterface

// File: rtl/video_in_store_burst.sv
// Drains pixel words from the video input FIFO into RAM with Wishbone classic bursts,
// one line at base + line*stride, with single-shot/continuous capture and bus error recovery.
module video_in_store_burst #(
    parameter int P_WIDTH       = 640,
    parameter int P_HEIGHT      = 480,
    parameter int BYTES_PER_PIX = 1,
    parameter int BURST_LEN     = 16,
    parameter int LVL_W         = 8,
    parameter int INT_CYCLES    = 3
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [31:0]            wb_reg_ctr,
    input  logic [31:0]            wb_reg_data,
    input  logic [31:0]            wb_reg_stride,
    input  logic [LVL_W-1:0]       fifo_level,
    input  logic [31:0]            data_fifo,
    output logic                   r_ack,
    output logic                   interrupt,
    output logic                   new_addr,
    output logic                   busy,
    output logic                   err_flag,
    video_in_store_burst_if.master p_wb
);
    localparam int WPL    = P_WIDTH * BYTES_PER_PIX / 4;
    localparam int WORD_W = $clog2(WPL + 1);
    localparam int LINE_W = $clog2(P_HEIGHT + 1);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam int ICNT_W = $clog2(INT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_BURST, S_IMG_DONE, S_ERROR} state_t;

    state_t            state;
    logic              ctr0_prev;
    logic              pend;
    logic [31:0]       base, stride, pend_base, pend_stride, line_base;
    logic [31:0]       restart_base, restart_stride;
    logic [WORD_W-1:0] word;
    logic [LINE_W-1:0] line;
    logic [BCNT_W-1:0] bcnt;
    logic [ICNT_W-1:0] int_cnt;
    logic              last_word, last_line, last_beat, int_last, addr_direct;
    logic              unused_ctr;

    assign new_addr    = wb_reg_ctr[0] & ~ctr0_prev;
    assign r_ack       = p_wb.ACK_I & p_wb.STB_O & ~p_wb.ERR_I;
    assign p_wb.SEL_O  = 4'hf;
    assign p_wb.DAT_O  = p_wb.STB_O ? data_fifo : 32'd0;
    assign unused_ctr  = ^wb_reg_ctr[31:2];

    assign last_word   = (word == WORD_W'(WPL - 1));
    assign last_line   = (line == LINE_W'(P_HEIGHT - 1));
    assign last_beat   = (bcnt == BCNT_W'(BURST_LEN - 1));
    assign int_last    = (int_cnt == ICNT_W'(INT_CYCLES - 1));
    assign addr_direct = (state == S_IDLE) || (state == S_ERROR);

    // A pending address, if any, takes effect at the next frame start
    assign restart_base   = pend ? pend_base   : base;
    assign restart_stride = pend ? pend_stride : stride;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            ctr0_prev   <= 1'b0;
            pend        <= 1'b0;
            base        <= 32'd0;
            stride      <= 32'd0;
            pend_base   <= 32'd0;
            pend_stride <= 32'd0;
            line_base   <= 32'd0;
            word        <= '0;
            line        <= '0;
            bcnt        <= '0;
            int_cnt     <= '0;
            busy        <= 1'b0;
            err_flag    <= 1'b0;
            interrupt   <= 1'b0;
            p_wb.CYC_O  <= 1'b0;
            p_wb.STB_O  <= 1'b0;
            p_wb.LOCK_O <= 1'b0;
            p_wb.WE_O   <= 1'b0;
            p_wb.ADR_O  <= 32'd0;
        end else begin
            ctr0_prev <= wb_reg_ctr[0];

            if (new_addr && addr_direct) begin
                base   <= wb_reg_data;
                stride <= wb_reg_stride;
                pend   <= 1'b0;
            end else if (new_addr) begin
                pend_base   <= wb_reg_data;
                pend_stride <= wb_reg_stride;
                pend        <= 1'b1;
            end

            if (interrupt) begin
                if (int_last) begin
                    interrupt <= 1'b0;
                    int_cnt   <= '0;
                end else begin
                    int_cnt <= int_cnt + ICNT_W'(1);
                end
            end

            case (state)
                S_IDLE, S_ERROR: begin
                    if (new_addr) begin
                        state      <= S_WAIT_DATA;
                        busy       <= 1'b1;
                        err_flag   <= 1'b0;
                        word       <= '0;
                        line       <= '0;
                        bcnt       <= '0;
                        line_base  <= wb_reg_data;
                        p_wb.ADR_O <= wb_reg_data;
                    end
                end

                S_WAIT_DATA: begin
                    if (int'(fifo_level) >= BURST_LEN) begin
                        state       <= S_BURST;
                        p_wb.CYC_O  <= 1'b1;
                        p_wb.STB_O  <= 1'b1;
                        p_wb.LOCK_O <= 1'b1;
                        p_wb.WE_O   <= 1'b1;
                    end
                end

                S_BURST: begin
                    // ERR wins over a simultaneous ACK: nothing popped, address held
                    if (p_wb.ERR_I) begin
                        state       <= S_ERROR;
                        p_wb.CYC_O  <= 1'b0;
                        p_wb.STB_O  <= 1'b0;
                        p_wb.LOCK_O <= 1'b0;
                        p_wb.WE_O   <= 1'b0;
                        busy        <= 1'b0;
                        err_flag    <= 1'b1;
                        interrupt   <= 1'b1;
                        int_cnt     <= '0;
                    end else if (p_wb.ACK_I) begin
                        if (last_word) begin
                            word       <= '0;
                            line       <= line + LINE_W'(1);
                            line_base  <= line_base + stride;
                            p_wb.ADR_O <= line_base + stride;
                        end else begin
                            word       <= word + WORD_W'(1);
                            p_wb.ADR_O <= p_wb.ADR_O + 32'd4;
                        end
                        if (last_beat) begin
                            bcnt        <= '0;
                            p_wb.CYC_O  <= 1'b0;
                            p_wb.STB_O  <= 1'b0;
                            p_wb.LOCK_O <= 1'b0;
                            p_wb.WE_O   <= 1'b0;
                            if (last_word && last_line) begin
                                state     <= S_IMG_DONE;
                                interrupt <= 1'b1;
                                int_cnt   <= '0;
                            end else begin
                                state <= S_WAIT_DATA;
                            end
                        end else begin
                            bcnt <= bcnt + BCNT_W'(1);
                        end
                    end
                end

                S_IMG_DONE: begin
                    if (int_last) begin
                        if (pend) begin
                            base   <= pend_base;
                            stride <= pend_stride;
                            if (!new_addr) pend <= 1'b0;
                        end
                        if (wb_reg_ctr[1]) begin
                            state      <= S_WAIT_DATA;
                            word       <= '0;
                            line       <= '0;
                            bcnt       <= '0;
                            line_base  <= restart_base;
                            p_wb.ADR_O <= restart_base;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_stride;
    assign unused_stride = ^restart_stride;
endmodule
